// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants for the data-memory stall responder.
//   ST_IDLE/ST_WAIT/ST_RESP - FSM state encodings
//   NUM_LANES               - byte lanes per 32-bit word
//   MAX_LATENCY, CNT_W      - largest legal latency and the counter width that holds it
package dmem_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   localparam int NUM_LANES = 4;
   localparam int MAX_LATENCY = 15;
   localparam int CNT_W = 4;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: synchronous-write, registered-read word storage with byte-lane write enables.
//   i_clk, i_rst   - clock; sync active-high reset (clears only the read register)
//   i_we, i_be     - word write strobe and per-lane enables
//   i_addr         - word index shared by read and write
//   i_wdata        - write data
//   i_re           - load the read register from the addressed word
//   i_clr          - force the read register to zero
//   o_rdata        - registered read data
module dmem_array
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_we,
   input  logic [NUM_LANES-1:0] i_be,
   input  logic [ADDR_W-1:0]    i_addr,
   input  logic [DATA_W-1:0]    i_wdata,
   input  logic                 i_re,
   input  logic                 i_clr,
   output logic [DATA_W-1:0]    o_rdata
);
   logic [NUM_LANES-1:0][7:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge i_clk)
      for (int l = 0; l < NUM_LANES; l++)
         if (i_we && i_be[l]) mem_q[i_addr][l] <= i_wdata[8*l +: 8];

   always_ff @(posedge i_clk)
      if (i_rst || i_clr) rdata_q <= '0;
      else if (i_re) rdata_q <= mem_q[i_addr];

   assign o_rdata = rdata_q;
endmodule

// File: rtl/dmem_stall_responder.sv
// dmem_stall_responder: fixed-latency data-memory responder that stalls the pipeline until its ack.
//   i_clk, i_rst  - clock; sync active-high reset (aborts any transaction in flight)
//   i_req, i_we   - MEM-stage request; 1 = store, 0 = load
//   i_addr        - byte address (word index in [ADDR_W+1:2], upper bits ignored)
//   i_wdata, i_be - store data and byte-lane enables
//   o_rdata       - registered load data, held until the next load or misaligned ack
//   o_ack         - one-cycle completion pulse
//   o_stall       - combinational freeze request, i_req & ~o_ack
//   o_misalign    - misaligned access, valid only with o_ack
// Build option: define DMEM_BYTE_LANE_EN to honour i_be on stores; otherwise stores write the full word.
module dmem_stall_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int LATENCY = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_req,
   input  logic                 i_we,
   input  logic [31:0]          i_addr,
   input  logic [DATA_W-1:0]    i_wdata,
   input  logic [NUM_LANES-1:0] i_be,
   output logic [DATA_W-1:0]    o_rdata,
   output logic                 o_ack,
   output logic                 o_stall,
   output logic                 o_misalign
);
   logic [1:0] state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] idx_q, idx_acc;
   logic [DATA_W-1:0] wdata_q, wdata_acc;
   logic [NUM_LANES-1:0] be_q, be_acc;
   logic we_q, mis_q, we_acc, mis_acc;
   logic accept, enter_resp, unused_bits;

   assign accept = (state_q == ST_IDLE) && i_req;
   assign enter_resp = (accept && LATENCY == 1) || (state_q == ST_WAIT && cnt_q == CNT_W'(1));

   // With LATENCY==1 the memory access happens on the accepting edge, so use the live inputs then.
   assign idx_acc   = accept ? i_addr[ADDR_W+1:2] : idx_q;
   assign we_acc    = accept ? i_we : we_q;
   assign mis_acc   = accept ? (i_addr[1:0] != 2'd0) : mis_q;
   assign wdata_acc = accept ? i_wdata : wdata_q;

`ifdef DMEM_BYTE_LANE_EN
   assign be_acc = accept ? i_be : be_q;
   assign unused_bits = ^i_addr[31:ADDR_W+2];
`else
   assign be_acc = '1;
   assign unused_bits = ^{i_addr[31:ADDR_W+2], be_q};
`endif

   always_comb begin
      state_d = state_q == ST_IDLE ? (i_req ? (LATENCY == 1 ? ST_RESP : ST_WAIT) : ST_IDLE) :
                state_q == ST_WAIT ? (cnt_q == CNT_W'(1) ? ST_RESP : ST_WAIT) : ST_IDLE;
      cnt_d   = accept ? CNT_W'(LATENCY - 1) : state_q == ST_WAIT ? cnt_q - CNT_W'(1) : cnt_q;
   end

   always_ff @(posedge i_clk)
      if (i_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end

   always_ff @(posedge i_clk)
      if (accept) begin
         idx_q   <= i_addr[ADDR_W+1:2];
         we_q    <= i_we;
         mis_q   <= i_addr[1:0] != 2'd0;
         wdata_q <= i_wdata;
         be_q    <= i_be;
      end

   // Reset on the entering edge suppresses the access so an aborted store never lands.
   dmem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_we    (enter_resp && we_acc && !mis_acc && !i_rst),
      .i_be    (be_acc),
      .i_addr  (idx_acc),
      .i_wdata (wdata_acc),
      .i_re    (enter_resp && !we_acc && !mis_acc && !i_rst),
      .i_clr   (enter_resp && mis_acc),
      .o_rdata (o_rdata)
   );

   assign o_ack      = state_q == ST_RESP;
   assign o_misalign = o_ack && mis_q;
   assign o_stall    = i_req && !o_ack;
endmodule

// File: tb/tb_dmem_stall_responder.sv
// tb_dmem_stall_responder: directed self-checking bench for three responder instances (LATENCY 2, 1, 4).
module tb_dmem_stall_responder;
   logic clk = 1'b0, rst = 1'b1, we = 1'b0;
   logic [2:0] req = 3'b000;
   logic [31:0] addr = '0, wdata = '0;
   logic [3:0] be = 4'hF;
   logic [2:0] ack, stall, mis;
   logic [31:0] rd [3];
   int n_chk = 0, n_fail = 0;
   int cyc, bad;
   logic [31:0] rdv;
   logic misv;

   always #5 clk = ~clk;

   dmem_stall_responder #(.LATENCY(2)) u_l2 (.i_clk(clk), .i_rst(rst), .i_req(req[0]), .i_we(we),
      .i_addr(addr), .i_wdata(wdata), .i_be(be), .o_rdata(rd[0]), .o_ack(ack[0]),
      .o_stall(stall[0]), .o_misalign(mis[0]));
   dmem_stall_responder #(.LATENCY(1)) u_l1 (.i_clk(clk), .i_rst(rst), .i_req(req[1]), .i_we(we),
      .i_addr(addr), .i_wdata(wdata), .i_be(be), .o_rdata(rd[1]), .o_ack(ack[1]),
      .o_stall(stall[1]), .o_misalign(mis[1]));
   dmem_stall_responder #(.LATENCY(4)) u_l4 (.i_clk(clk), .i_rst(rst), .i_req(req[2]), .i_we(we),
      .i_addr(addr), .i_wdata(wdata), .i_be(be), .o_rdata(rd[2]), .o_ack(ack[2]),
      .o_stall(stall[2]), .o_misalign(mis[2]));

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One transaction on instance k; cyc = negedges until ack, bad counts protocol violations
   // (stall low before ack, misalign outside ack, stall high in ack, ack lingering).
   task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, output int c, output logic [31:0] r, output logic m,
                      output int bd);
      we = w; addr = a; wdata = d; be = b; req[k] = 1'b1; c = 0; bd = 0;
      #1 if (stall[k] !== 1'b1) bd++;
      do begin
         @(negedge clk);
         c++;
         if (!ack[k] && (stall[k] !== 1'b1 || mis[k] !== 1'b0)) bd++;
      end while (ack[k] !== 1'b1 && c < 20);
      if (stall[k] !== 1'b0) bd++;
      r = rd[k]; m = mis[k]; req[k] = 1'b0;
      @(negedge clk);
      if (ack[k] !== 1'b0 || mis[k] !== 1'b0) bd++;
   endtask

   // Hold a load request for three back-to-back transactions and measure ack spacing.
   task automatic sweep(input int k, input int lat, input string tag);
      int n = 0;
      int t [3] = '{0, 0, 0};
      we = 1'b0; addr = 32'h10; req[k] = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (ack[k]) begin
            if (n < 3) t[n] = c;
            n++;
            if (n == 3) req[k] = 1'b0;
         end
      end
      req[k] = 1'b0;
      check({tag, " ack count"}, n, 3);
      check({tag, " first ack"}, t[0], lat);
      check({tag, " spacing 1"}, t[1] - t[0], lat + 1);
      check({tag, " spacing 2"}, t[2] - t[1], lat + 1);
      check({tag, " rdata"}, rd[k], 32'h0BADF00D);
   endtask

   initial begin
      req[0] = 1'b1;
      repeat (2) @(negedge clk);
      check("reset ack", ack[0], 0);
      check("reset rdata", rd[0], 0);
      check("reset misalign", mis[0], 0);
      check("stall during reset", stall[0], 1);
      req[0] = 1'b0; rst = 1'b0;
      @(negedge clk);
      check("idle stall", stall[0], 0);

      txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, cyc, rdv, misv, bad);
      check("store latency", cyc, 2);
      check("store protocol", bad, 0);
      check("store misalign", misv, 0);
      check("store rdata untouched", rdv, 0);

      txn(0, 1'b0, 32'h10, 32'h0, 4'hF, cyc, rdv, misv, bad);
      check("load latency", cyc, 2);
      check("load protocol", bad, 0);
      check("load data", rdv, 32'hDEADBEEF);
      repeat (3) @(negedge clk);
      check("load data held", rd[0], 32'hDEADBEEF);

      txn(0, 1'b1, 32'h14, 32'h00000001, 4'hF, cyc, rdv, misv, bad);
      check("store keeps rdata", rdv, 32'hDEADBEEF);

      txn(0, 1'b0, 32'h13, 32'h0, 4'hF, cyc, rdv, misv, bad);
      check("misaligned load flag", misv, 1);
      check("misaligned load rdata", rdv, 0);
      check("misaligned load protocol", bad, 0);
      txn(0, 1'b1, 32'h11, 32'h12345678, 4'hF, cyc, rdv, misv, bad);
      check("misaligned store flag", misv, 1);
      txn(0, 1'b0, 32'h10, 32'h0, 4'hF, cyc, rdv, misv, bad);
      check("after misaligned", rdv, 32'hDEADBEEF);
      check("after misaligned flag", misv, 0);

      txn(0, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, cyc, rdv, misv, bad);
      txn(0, 1'b0, 32'h0, 32'h0, 4'hF, cyc, rdv, misv, bad);
      check("wrap to word 0", rdv, 32'hCAFEF00D);

      txn(0, 1'b1, 32'h20, 32'h55550000, 4'hF, cyc, rdv, misv, bad);
      we = 1'b1; addr = 32'h20; wdata = 32'h99999999; req[0] = 1'b1;
      @(negedge clk);
      rst = 1'b1; req[0] = 1'b0;
      bad = 0;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (ack[0]) bad++;
      end
      check("abort no ack", bad, 0);
      txn(0, 1'b0, 32'h20, 32'h0, 4'hF, cyc, rdv, misv, bad);
      check("abort keeps old", rdv, 32'h55550000);

      txn(0, 1'b1, 32'h30, 32'hAAAAAAAA, 4'hF, cyc, rdv, misv, bad);
      txn(0, 1'b1, 32'h30, 32'h11223344, 4'b0101, cyc, rdv, misv, bad);
      txn(0, 1'b0, 32'h30, 32'h0, 4'hF, cyc, rdv, misv, bad);
`ifdef DMEM_BYTE_LANE_EN
      check("byte lanes", rdv, 32'hAA22AA44);
`else
      check("byte lanes", rdv, 32'h11223344);
`endif

      txn(1, 1'b1, 32'h10, 32'h0BADF00D, 4'hF, cyc, rdv, misv, bad);
      check("L1 store latency", cyc, 1);
      check("L1 store protocol", bad, 0);
      sweep(1, 1, "L1");
      txn(2, 1'b1, 32'h10, 32'h0BADF00D, 4'hF, cyc, rdv, misv, bad);
      check("L4 store latency", cyc, 4);
      check("L4 store protocol", bad, 0);
      sweep(2, 4, "L4");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/dmem_stall_responder.md
Name: dmem_stall_responder

Overview:
- Multi-cycle data-memory responder for the MEM stage of the pipelined CPU.
- The CPU's MEM stage is the initiator; this block is the responder.
- Accepts one load/store request at a time and returns a one-cycle ack after a fixed latency.
- Drives a combinational stall so the hazard unit freezes PC/IF/ID/EX and the MEM stage until the ack.

Parameters:
- ADDR_W, 8, word-index bits; depth = 2**ADDR_W words.
- DATA_W, 32, data word width; must be 32.
- LATENCY, 2, rising edges from request acceptance to the edge that raises o_ack; legal range 1..15.

Ports:
- i_clk  input  1  clock; all logic is rising-edge.
- i_rst  input  1  synchronous reset, active-high.
- i_req  input  1  MEM stage holds a load or store.
- i_we  input  1  1 = store, 0 = load.
- i_addr  input  32  byte address.
- i_wdata  input  32  store data.
- i_be  input  4  byte-lane write enables; always present, used only with the macro.
- o_rdata  output  32  load data; registered.
- o_ack  output  1  transaction complete; one-cycle pulse.
- o_stall  output  1  pipeline freeze request; combinational.
- o_misalign  output  1  misaligned access; qualified by o_ack.

Behaviour:
- Reset (i_rst=1 at an edge): state=IDLE, cnt=0, o_ack=0, o_rdata=0, o_misalign=0. Memory contents are not reset.
- Reset mid-transaction aborts it: no write is performed and no ack is issued.
- State machine, states IDLE, WAIT, RESP:
  - IDLE with i_req=1 at an edge: capture addr, we, wdata, be; load cnt=LATENCY-1. Go to RESP if LATENCY==1, else WAIT.
  - WAIT: decrement cnt each edge; at the edge where cnt==1, go to RESP.
  - RESP: o_ack=1 for exactly this cycle; next edge returns to IDLE unconditionally.
  - Any i_req seen while in RESP is ignored.
- Latency: request sampled at edge E0 gives o_ack high in the cycle following edge E0+LATENCY-1. Each transaction occupies LATENCY+1 cycles including the IDLE turnaround.
- Memory access is performed at the edge entering RESP:
  - Store: writes captured wdata to mem[addr[ADDR_W+1:2]]; o_rdata unchanged.
  - Load: o_rdata <= mem[index]; the value is held until the next load ack.
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo the depth.
- Misaligned access (captured addr[1:0] != 0):
  - No memory read or write.
  - o_ack=1 with o_misalign=1; o_rdata forced to 0.
  - o_misalign is 0 in every cycle where o_ack=0.
- o_stall = i_req & ~o_ack.
  - Asserted in IDLE while a request is pending, so the pipeline holds during the acceptance cycle.
  - Deasserted in the ack cycle, letting the pipeline advance exactly once.
- i_req dropping mid-transaction does not cancel it; the captured request completes.
- Back-to-back requests: a new request is accepted in the IDLE cycle that follows RESP.

Optional Feature:
- Macro DMEM_BYTE_LANE_EN.
- Defined: a store updates only the byte lanes whose captured i_be bit is 1; i_be=4'b0000 gives a store that is acked with no write.
- Undefined: i_be is ignored and every aligned store writes the full word.
- Loads always return the full word in both builds.

Decomposition:
- Shared package dmem_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_WAIT=2'd1, ST_RESP=2'd2;
  - lane count NUM_LANES=4;
  - localparam MAX_LATENCY=15 and the cnt width 4.
- One sub-module, dmem_array: synchronous-write, registered-read word storage with per-lane write enables (tied high when the macro is undefined).
- FSM, counter and misalign logic stay in the top level.

Test Plan:
- Reset, then aligned store: LATENCY=2; store 32'hDEADBEEF at 0x10; release reset -> req accepted at E0, o_ack pulses in the cycle after E1, o_stall=1 through the ack cycle minus one, o_misalign=0.
- Load after store: load from 0x10 -> o_rdata=32'hDEADBEEF in the ack cycle and held afterwards; a subsequent store leaves o_rdata unchanged.
- Misaligned load/store: access 0x13 -> ack with o_misalign=1 and o_rdata=0; a following load from 0x10 still returns 32'hDEADBEEF.
- Back-to-back and latency sweep: 3 consecutive loads with LATENCY=1 and LATENCY=4 -> acks spaced exactly 2 and 5 cycles apart; exactly one o_ack per request.
- Wrap and abort: store to 0x400 (ADDR_W=8) -> word 0 written; assert i_rst in WAIT during a store to 0x20 -> no ack, and a later load of 0x20 returns the old value.
- DMEM_BYTE_LANE_EN: store 32'h11223344 with be=4'b0101 over 32'hAAAAAAAA -> readback 32'hAA22AA44; without the macro -> 32'h11223344.
